riscv_mem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the load/store unit (port m0) and instruction fetch (port m1).
- Sits between both requesters and the memory; uses the same req/ready memory protocol on every side.
- Holds a grant for a whole transaction, selects the next winner in the completion cycle, and aborts a hung transaction with an error after a timeout.

---
 rtl/riscv_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one data-memory port between LSU (m0) and
// instruction fetch (m1) with per-transaction grant and hang timeout.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   m0_*/m1_*             requester side: req/we/be/addr/wd in,
//                         rd/ready/err out (err valid with ready)
//   mem_*                 memory side: req/we/be/addr/wd out,
//                         rd/ready in
//   busy_o, grant_o       not-idle flag, current owner (1 = m1)
//
// Optional feature: define ARB_RR_EN for round-robin tie-break
// (default build: fixed priority, m0 wins ties).
module riscv_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wd_i,
  output logic [31:0] m0_rd_o,
  output logic        m0_ready_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wd_i,
  output logic [31:0] m1_rd_o,
  output logic        m1_ready_o,
  output logic        m1_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        busy_o,
  output logic        grant_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_M0   = 2'd1;
  localparam logic [1:0] S_M1   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;

  logic busy, own0, own1;
  logic to_hit, done, err;
  logic tie_m1, idle_m1;

  assign busy = (state_q != S_IDLE);
  assign own0 = (state_q == S_M0);
  assign own1 = (state_q == S_M1);

  assign to_hit = busy & (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  // Reset cycle swallows any completion so no pulse escapes.
  assign done = busy & (mem_ready_i | to_hit) & ~rst_i;
  assign err  = to_hit & ~mem_ready_i & ~rst_i;

`ifdef ARB_RR_EN
  assign tie_m1 = ~last_q;
`else
  logic unused_last;
  assign unused_last = last_q;
  assign tie_m1 = 1'b0;
`endif

  assign idle_m1 = m1_req_i & (~m0_req_i | tie_m1);

  // On completion only the other requester is considered; the
  // finishing one is treated as served for this cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (m0_req_i | m1_req_i) begin
          state_d = idle_m1 ? S_M1 : S_M0;
          cnt_d   = '0;
          last_d  = idle_m1;
        end
      end
      S_M0: begin
        if (done) begin
          cnt_d = '0;
          if (m1_req_i) begin
            state_d = S_M1;
            last_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_M1: begin
        if (done) begin
          cnt_d = '0;
          if (m0_req_i) begin
            state_d = S_M0;
            last_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign busy_o    = busy;
  assign grant_o   = own1;
  assign mem_req_o = busy;

  always_comb begin
    mem_we_o   = 1'b0;
    mem_be_o   = '0;
    mem_addr_o = '0;
    mem_wd_o   = '0;
    unique case (1'b1)
      own0: begin
        mem_we_o   = m0_we_i;
        mem_be_o   = m0_be_i;
        mem_addr_o = m0_addr_i;
        mem_wd_o   = m0_wd_i;
      end
      own1: begin
        mem_we_o   = m1_we_i;
        mem_be_o   = m1_be_i;
        mem_addr_o = m1_addr_i;
        mem_wd_o   = m1_wd_i;
      end
      default: ;
    endcase
  end

  assign m0_ready_o = own0 & done;
  assign m1_ready_o = own1 & done;
  assign m0_err_o   = own0 & err;
  assign m1_err_o   = own1 & err;

  assign m0_rd_o = (own0 & mem_ready_i & ~rst_i) ? mem_rd_i : '0;
  assign m1_rd_o = (own1 & mem_ready_i & ~rst_i) ? mem_rd_i : '0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_riscv_mem_arbiter;

  localparam int TO = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_req_i = 0, m0_we_i = 0;
  logic [3:0]  m0_be_i = 0;
  logic [31:0] m0_addr_i = 0, m0_wd_i = 0;
  logic [31:0] m0_rd_o;
  logic        m0_ready_o, m0_err_o;
  logic        m1_req_i = 0, m1_we_i = 0;
  logic [3:0]  m1_be_i = 0;
  logic [31:0] m1_addr_i = 0, m1_wd_i = 0;
  logic [31:0] m1_rd_o;
  logic        m1_ready_o, m1_err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o;
  logic [31:0] mem_rd_i = 0;
  logic        mem_ready_i = 0;
  logic        busy_o, grant_o;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_addr_i(m0_addr_i), .m0_wd_i(m0_wd_i), .m0_rd_o(m0_rd_o),
    .m0_ready_o(m0_ready_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_addr_i(m1_addr_i), .m1_wd_i(m1_wd_i), .m1_rd_o(m1_rd_o),
    .m1_ready_o(m1_ready_o), .m1_err_o(m1_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
    .mem_ready_i(mem_ready_i), .busy_o(busy_o), .grant_o(grant_o)
  );

  // {busy, grant, mem_req, m0_ready, m1_ready, m0_err, m1_err}
  function automatic logic [6:0] ctl();
    return {busy_o, grant_o, mem_req_o, m0_ready_o, m1_ready_o,
            m0_err_o, m1_err_o};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic r, input logic a, input logic b,
                     input logic y);
    rst_i = r; m0_req_i = a; m1_req_i = b; mem_ready_i = y;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic rst, r0, r1, rdy;
    logic busy, gnt, er0, er1;
  } vec_t;

  vec_t tbl [16];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [6:0] ev;
    logic       g;
    int         own, wt, lst, nxt;
    bit         b, dn, tmo, er, s0, s1;
    logic [68:0] ep;
    logic [63:0] er_d;

    tbl = '{
      8'b1000_0000, 8'b0000_0000,
      8'b0110_0000, 8'b0111_1010, 8'b0011_1101,
      8'b0100_0000, 8'b0100_1000, 8'b0100_1000,
      8'b0101_1010, 8'b0000_0000,
      8'b0100_0000, 8'b0111_1010, 8'b0111_1101,
      8'b0101_1010, 8'b0000_0000, 8'b0000_0000
    };

    m0_addr_i = 32'h100; m1_addr_i = 32'h400;
    mem_rd_i  = 32'hDEADBEEF;
    drv(1, 0, 0, 0);
    adv(); adv();

    for (int i = 0; i < 16; i++) begin
      drv(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].rdy);
      #4;
      ev = {tbl[i].busy, tbl[i].gnt, tbl[i].busy, tbl[i].er0,
            tbl[i].er1, 2'b00};
      chk($sformatf("vec%0d_ctl", i), 128'(ctl()), 128'(ev));
      chk($sformatf("vec%0d_rd0", i), 128'(m0_rd_o),
          128'(tbl[i].er0 ? 32'hDEADBEEF : 32'h0));
      chk($sformatf("vec%0d_rd1", i), 128'(m1_rd_o),
          128'(tbl[i].er1 ? 32'hDEADBEEF : 32'h0));
      chk($sformatf("vec%0d_addr", i), 128'(mem_addr_o),
          128'(!tbl[i].busy ? 32'h0 :
               tbl[i].gnt ? 32'h400 : 32'h100));
      adv();
    end

    // second tie: last grant was m0, so round-robin picks m1
    g = RR;
    drv(0, 1, 1, 0); #4; adv();
    drv(0, 1, 1, 1); #4;
    chk("tie2_first", 128'(ctl()),
        128'({1'b1, g, 1'b1, ~g, g, 2'b00}));
    adv();
    drv(0, g, ~g, 1); #4;
    chk("tie2_second", 128'(ctl()),
        128'({1'b1, ~g, 1'b1, g, ~g, 2'b00}));
    adv();
    drv(0, 0, 0, 0); #4;
    chk("tie2_idle", 128'(ctl()), 128'(0));
    adv();

    // timeout on m1, memory never ready
    mem_rd_i = 32'h12345678;
    drv(0, 0, 1, 0); #4; adv();
    for (int k = 0; k <= TO; k++) begin
      #4;
      chk($sformatf("to_k%0d", k), 128'(ctl()),
          128'({3'b111, 1'b0, k == TO, 1'b0, k == TO}));
      chk($sformatf("to_rd_k%0d", k), 128'(m1_rd_o), 128'(0));
      adv();
      if (k == TO) m1_req_i = 1'b0;
    end
    #4;
    chk("to_after", 128'(busy_o), 128'(0));
    adv();

    // ready on the same cycle as the timeout: normal completion
    drv(0, 1, 0, 0); #4; adv();
    for (int k = 0; k < TO; k++) adv();
    mem_ready_i = 1'b1; #4;
    chk("to_rdy_ctl", 128'(ctl()), 128'(7'b1011000));
    chk("to_rdy_rd", 128'(m0_rd_o), 128'(32'h12345678));
    adv();
    drv(0, 0, 0, 0); #4; adv();

    // write payload, then reset during a second write
    m0_we_i = 1; m0_be_i = 4'h3;
    m0_addr_i = 32'h200; m0_wd_i = 32'h0000ABCD;
    drv(0, 1, 0, 0); #4; adv();
    #4;
    chk("wr_pay", 128'({mem_we_o, mem_be_o, mem_addr_o, mem_wd_o}),
        128'({1'b1, 4'h3, 32'h200, 32'h0000ABCD}));
    mem_ready_i = 1'b1; #1;
    chk("wr_done", 128'(ctl()), 128'(7'b1011000));
    adv();
    m0_wd_i = 32'h1111; drv(0, 1, 0, 0); #4;
    chk("wr2_start", 128'(busy_o), 128'(0));
    adv(); #4;
    chk("wr2_busy", 128'(ctl()), 128'(7'b1010000));
    adv();
    drv(1, 1, 0, 0); #4;
    chk("rst_cyc", 128'(ctl()), 128'(7'b1010000));
    adv();
    drv(0, 0, 0, 0); #4;
    chk("rst_after", 128'(ctl()), 128'(0));
    adv();

    // randomized run against a transaction-level model
    m0_we_i = 0; m0_be_i = 0;
    drv(1, 0, 0, 0); adv();
    rst_i = 1'b0;
    own = -1; wt = 0; lst = 1;
    for (int c = 0; c < 400; c++) begin
      mem_ready_i = ($urandom_range(0, 3) == 0);
      mem_rd_i = $urandom;
      #4;
      b   = (own >= 0);
      tmo = b && (wt == TO);
      dn  = b && (mem_ready_i || tmo);
      er  = tmo && !mem_ready_i;
      s0  = dn && own == 0;
      s1  = dn && own == 1;
      ev = {b, own == 1, b, s0, s1, er && own == 0, er && own == 1};
      ep = (own == 0) ? {m0_we_i, m0_be_i, m0_addr_i, m0_wd_i} :
           (own == 1) ? {m1_we_i, m1_be_i, m1_addr_i, m1_wd_i} : '0;
      er_d = {(s0 && !er) ? mem_rd_i : 32'h0,
              (s1 && !er) ? mem_rd_i : 32'h0};
      chk($sformatf("rnd%0d_ctl", c), 128'(ctl()), 128'(ev));
      chk($sformatf("rnd%0d_pay", c),
          128'({mem_we_o, mem_be_o, mem_addr_o, mem_wd_o}), 128'(ep));
      chk($sformatf("rnd%0d_rd", c), 128'({m0_rd_o, m1_rd_o}),
          128'(er_d));
      if (!b) begin
        nxt = -1;
        if (m0_req_i && m1_req_i) nxt = (RR && lst == 0) ? 1 : 0;
        else if (m0_req_i) nxt = 0;
        else if (m1_req_i) nxt = 1;
        if (nxt >= 0) lst = nxt;
        own = nxt; wt = 0;
      end else if (dn) begin
        nxt = 1 - own;
        if ((nxt == 0 && m0_req_i) || (nxt == 1 && m1_req_i)) begin
          own = nxt; lst = nxt;
        end else begin
          own = -1;
        end
        wt = 0;
      end else begin
        wt++;
      end
      adv();
      if (s0 || !m0_req_i) begin
        m0_req_i = s0 ? 1'($urandom_range(0, 1))
                      : ($urandom_range(0, 2) == 0);
        m0_we_i = 1'($urandom_range(0, 1));
        m0_be_i = 4'($urandom); m0_addr_i = $urandom;
        m0_wd_i = $urandom;
      end
      if (s1 || !m1_req_i) begin
        m1_req_i = s1 ? 1'($urandom_range(0, 1))
                      : ($urandom_range(0, 2) == 0);
        m1_we_i = 1'($urandom_range(0, 1));
        m1_be_i = 4'($urandom); m1_addr_i = $urandom;
        m1_wd_i = $urandom;
      end
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
